// File: rtl/mac_tx_arbiter.sv
`default_nettype none
// ============================================================================
// mac_tx_arbiter : round-robin owner of the MAC transmit path (ARP vs IP)
// Revision: 1.0
// ============================================================================
module mac_tx_arbiter #(
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_tx_req,
  input  logic        ip_tx_req,
  output logic        arp_tx_ready,
  output logic        ip_tx_ready,
  output logic        mac_tx_start,
  output logic        mac_tx_sel,
  input  logic        mac_tx_end,
  output logic        tx_busy,
  output logic        tx_timeout_err,
  output logic [15:0] arp_grant_cnt,
  output logic [15:0] ip_grant_cnt
);

  localparam logic [7:0]  GAP_LAST = 8'(IFG_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        last_ip_q, last_ip_d;
  logic        err_q, err_d;
  logic [15:0] arp_cnt_q, arp_cnt_d;
  logic [15:0] ip_cnt_q, ip_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_ip_d = last_ip_q;
    err_d     = 1'b0;
    arp_cnt_d = arp_cnt_q;
    ip_cnt_d  = ip_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (arp_tx_req || ip_tx_req) begin
          // On a tie the requester that did not win last time goes next.
          sel_d     = (arp_tx_req && ip_tx_req) ? !last_ip_q : ip_tx_req;
          last_ip_d = sel_d;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (sel_q) begin
          if (ip_cnt_q != 16'hffff) ip_cnt_d = ip_cnt_q + 16'd1;
        end else begin
          if (arp_cnt_q != 16'hffff) arp_cnt_d = arp_cnt_q + 16'd1;
        end
        tmo_cnt_d = 16'd0;
        state_d   = BUSY;
      end
      BUSY: begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        if (mac_tx_end) begin
          gap_cnt_d = 8'd0;
          state_d   = GAP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_d     = 1'b1;
          gap_cnt_d = 8'd0;
          state_d   = GAP;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 8'd1;
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      last_ip_q <= 1'b1;
      err_q     <= 1'b0;
      arp_cnt_q <= 16'd0;
      ip_cnt_q  <= 16'd0;
      tmo_cnt_q <= 16'd0;
      gap_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_ip_q <= last_ip_d;
      err_q     <= err_d;
      arp_cnt_q <= arp_cnt_d;
      ip_cnt_q  <= ip_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign arp_tx_ready   = (state_q == GRANT) && !sel_q;
  assign ip_tx_ready    = (state_q == GRANT) && sel_q;
  assign mac_tx_start   = (state_q == GRANT);
  assign mac_tx_sel     = sel_q;
  assign tx_busy        = (state_q != IDLE);
  assign tx_timeout_err = err_q;
  assign arp_grant_cnt  = arp_cnt_q;
  assign ip_grant_cnt   = ip_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mac_tx_arbiter : random frame traffic against a timeline model of the arbiter
// Revision: 1.0
// ============================================================================
module tb_mac_tx_arbiter;

  localparam int IFG = 12;
  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arp_tx_req = 1'b0;
  logic        ip_tx_req = 1'b0;
  logic        mac_tx_end = 1'b0;
  logic        arp_tx_ready, ip_tx_ready, mac_tx_start, mac_tx_sel;
  logic        tx_busy, tx_timeout_err;
  logic [15:0] arp_grant_cnt, ip_grant_cnt;

  mac_tx_arbiter #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .arp_tx_req     (arp_tx_req),
    .ip_tx_req      (ip_tx_req),
    .arp_tx_ready   (arp_tx_ready),
    .ip_tx_ready    (ip_tx_ready),
    .mac_tx_start   (mac_tx_start),
    .mac_tx_sel     (mac_tx_sel),
    .mac_tx_end     (mac_tx_end),
    .tx_busy        (tx_busy),
    .tx_timeout_err (tx_timeout_err),
    .arp_grant_cnt  (arp_grant_cnt),
    .ip_grant_cnt   (ip_grant_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen with no expectation queued (cycle %0d)", name, cyc);
  endfunction

  typedef struct {
    logic        ip;
    int          at;
    logic [15:0] arp_cnt;
    logic [15:0] ip_cnt;
  } grant_t;

  grant_t gq[$];
  int     errq[$];
  int     idleq[$];

  // Monitor: pops expectations whenever the DUT shows a grant, error or return to idle.
  logic   exp_sel   = 1'b0;
  logic   busy_prev = 1'b0;
  logic   cnt_pend  = 1'b0;
  grant_t cur;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (cnt_pend) begin
        check("arp_grant_cnt", arp_grant_cnt, cur.arp_cnt);
        check("ip_grant_cnt", ip_grant_cnt, cur.ip_cnt);
        cnt_pend = 1'b0;
      end
      if (arp_tx_ready || ip_tx_ready) begin
        if (gq.size() == 0) begin
          unexpected("grant");
        end else begin
          cur = gq.pop_front();
          check("grant_cycle", cyc, cur.at);
          check("grant_is_ip", ip_tx_ready, cur.ip);
          check("grant_one_hot", arp_tx_ready && ip_tx_ready, 0);
          check("start_with_grant", mac_tx_start, 1);
          check("busy_at_grant", tx_busy, 1);
          exp_sel  = cur.ip;
          cnt_pend = 1'b1;
        end
      end else begin
        check("start_without_grant", mac_tx_start, 0);
      end
      check("mac_tx_sel", mac_tx_sel, exp_sel);
      if (tx_timeout_err) begin
        if (errq.size() == 0) unexpected("tx_timeout_err");
        else check("timeout_cycle", cyc, errq.pop_front());
      end
      if (busy_prev && !tx_busy) begin
        if (idleq.size() == 0) unexpected("return_to_idle");
        else check("idle_cycle", cyc, idleq.pop_front());
      end
      busy_prev = tx_busy;
    end
  end

  // Reference model state: who won last and how many grants each side has had.
  logic        lg_ip = 1'b1;
  logic [15:0] m_arp = 16'd0;
  logic [15:0] m_ip  = 16'd0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic garbage();
    arp_tx_req = 1'($urandom);
    ip_tx_req  = 1'($urandom);
    mac_tx_end = ($urandom_range(0, 3) == 0);
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  // Called in a cycle where the arbiter is idle; runs one whole frame plus gap.
  task automatic frame(input logic a, input logic i);
    int     c, k, kk, t;
    logic   w;
    grant_t g;
    arp_tx_req = a;
    ip_tx_req  = i;
    mac_tx_end = 1'($urandom);
    w     = (a && i) ? !lg_ip : i;
    lg_ip = w;
    if (w) m_ip = sat_inc(m_ip);
    else   m_arp = sat_inc(m_arp);
    c = cyc;
    g.ip = w; g.at = c + 1; g.arp_cnt = m_arp; g.ip_cnt = m_ip;
    gq.push_back(g);
    tick();
    garbage();
    tick();
    case ($urandom_range(0, 7))
      0:       k = TMO;
      1:       k = TMO - 1;
      default: k = $urandom_range(0, 60);
    endcase
    kk = (k >= TMO) ? TMO - 1 : k;
    t  = c + 2 + kk;
    if (k >= TMO) errq.push_back(t + 1);
    idleq.push_back(t + 1 + IFG);
    for (int j = 0; j <= kk; j++) begin
      garbage();
      mac_tx_end = (j == k);
      tick();
    end
    repeat (IFG) begin
      garbage();
      tick();
    end
    arp_tx_req = 1'b0;
    ip_tx_req  = 1'b0;
    mac_tx_end = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     r, c;
    grant_t g;
    repeat (3) tick();
    check("reset_busy", tx_busy, 0);
    check("reset_arp_ready", arp_tx_ready, 0);
    check("reset_ip_ready", ip_tx_ready, 0);
    check("reset_err", tx_timeout_err, 0);
    check("reset_arp_cnt", arp_grant_cnt, 0);
    check("reset_ip_cnt", ip_grant_cnt, 0);
    rst = 1'b0;

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) begin
        mac_tx_end = 1'($urandom);
        tick();
      end
      r = $urandom_range(1, 3);
      frame(r[0], r[1]);
    end

    for (int n = 0; n < 4; n++) frame(1'b1, 1'b1);

    // Reset five cycles into BUSY with the ARP request still asserted.
    arp_tx_req = 1'b1;
    ip_tx_req  = 1'b0;
    c     = cyc;
    lg_ip = 1'b0;
    m_arp = sat_inc(m_arp);
    g.ip = 1'b0; g.at = c + 1; g.arp_cnt = m_arp; g.ip_cnt = m_ip;
    gq.push_back(g);
    tick();
    tick();
    repeat (5) tick();
    rst = 1'b1;
    idleq.push_back(c + 8);
    tick();
    check("midreset_busy", tx_busy, 0);
    check("midreset_arp_ready", arp_tx_ready, 0);
    check("midreset_start", mac_tx_start, 0);
    check("midreset_sel", mac_tx_sel, 0);
    check("midreset_err", tx_timeout_err, 0);
    check("midreset_arp_cnt", arp_grant_cnt, 0);
    check("midreset_ip_cnt", ip_grant_cnt, 0);
    rst   = 1'b0;
    m_arp = 16'd1;
    m_ip  = 16'd0;
    lg_ip = 1'b0;
    g.ip = 1'b0; g.at = c + 9; g.arp_cnt = m_arp; g.ip_cnt = m_ip;
    gq.push_back(g);
    tick();
    arp_tx_req = 1'b0;
    tick();
    mac_tx_end = 1'b1;
    idleq.push_back(cyc + 1 + IFG);
    tick();
    mac_tx_end = 1'b0;
    repeat (IFG + 4) tick();

    check("grants_outstanding", gq.size(), 0);
    check("timeouts_outstanding", errq.size(), 0);
    check("idles_outstanding", idleq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
